// File: rtl/cpu_defs.sv
// Shared CPU definitions: ALU operation codes, MIPS opcode/funct
// constants and the ID/EX bundle types used by issue and ALU logic.
package cpu_defs;

    // ALU operation codes
    localparam logic [3:0] ALUC_ADD  = 4'b0000;
    localparam logic [3:0] ALUC_SUB  = 4'b0001;
    localparam logic [3:0] ALUC_ADDO = 4'b0010;
    localparam logic [3:0] ALUC_AND  = 4'b0011;
    localparam logic [3:0] ALUC_OR   = 4'b0100;
    localparam logic [3:0] ALUC_NOR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR  = 4'b0110;
    localparam logic [3:0] ALUC_SLL  = 4'b1000;
    localparam logic [3:0] ALUC_MOVN = 4'b1100;
    localparam logic [3:0] ALUC_MOVZ = 4'b1110;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_MOVZ = 6'b001010;
    localparam logic [5:0] FN_MOVN = 6'b001011;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // lui is executed as imm << 16
    localparam logic [4:0] LUI_SHAMT = 5'd16;

    typedef enum logic [1:0] {
        IMM_NONE,
        IMM_SEXT,
        IMM_ZEXT
    } imm_t;

    typedef enum logic {
        ST_RUN,
        ST_BUBBLE
    } issue_st_t;

    typedef struct packed {
        logic [3:0] aluc;
        imm_t       imm;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wreg;
        logic [4:0] shamt;
        logic       rt_src;
        logic       rf_w;
        logic       mem_r;
        logic       mem_w;
        logic       illegal;
    } dec_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [3:0]  aluc;
        logic        rf_w;
        logic [4:0]  wreg;
        logic        mem_r;
        logic        mem_w;
        logic        illegal;
    } ex_t;

    // Select the ALU b operand: register or extended immediate
    function automatic logic [31:0] ext_imm(
        input imm_t        mode,
        input logic [15:0] imm,
        input logic [31:0] rt_val
    );
        logic [31:0] v;
        v = rt_val;
        if (mode == IMM_SEXT)
            v = {{16{imm[15]}}, imm};
        else if (mode == IMM_ZEXT)
            v = {16'h0000, imm};
        return v;
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decode for the ALU issue slot:
// instruction word -> ALU op, immediate mode, dest reg and flags.
module alu_decode
    import cpu_defs::*;
(
    input  logic [31:0] i_instr,
    output dec_t        o_dec
);

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic [4:0] w_sa;
    dec_t       w_dec;

    assign w_op = i_instr[31:26];
    assign w_rs = i_instr[25:21];
    assign w_rt = i_instr[20:16];
    assign w_rd = i_instr[15:11];
    assign w_sa = i_instr[10:6];
    assign w_fn = i_instr[5:0];

    // Opcode/funct table; unknown encodings become a harmless illegal op
    always_comb begin
        w_dec      = '0;
        w_dec.aluc = ALUC_ADD;
        w_dec.imm  = IMM_NONE;
        w_dec.rs   = w_rs;
        w_dec.rt   = w_rt;
        case (w_op)
            OP_RTYPE: begin
                w_dec.wreg   = w_rd;
                w_dec.rt_src = 1'b1;
                w_dec.rf_w   = 1'b1;
                case (w_fn)
                    FN_ADD:  w_dec.aluc = ALUC_ADDO;
                    FN_ADDU: w_dec.aluc = ALUC_ADD;
                    FN_SUB,
                    FN_SUBU,
                    FN_SLT:  w_dec.aluc = ALUC_SUB;
                    FN_AND:  w_dec.aluc = ALUC_AND;
                    FN_OR:   w_dec.aluc = ALUC_OR;
                    FN_XOR:  w_dec.aluc = ALUC_XOR;
                    FN_NOR:  w_dec.aluc = ALUC_NOR;
                    FN_MOVZ: w_dec.aluc = ALUC_MOVZ;
                    FN_MOVN: w_dec.aluc = ALUC_MOVN;
                    FN_SLL: begin
                        w_dec.aluc  = ALUC_SLL;
                        w_dec.shamt = w_sa;
                    end
                    default: w_dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                w_dec.aluc = ALUC_ADDO;
                w_dec.imm  = IMM_SEXT;
                w_dec.wreg = w_rt;
                w_dec.rf_w = 1'b1;
            end
            OP_ADDIU: begin
                w_dec.aluc = ALUC_ADD;
                w_dec.imm  = IMM_SEXT;
                w_dec.wreg = w_rt;
                w_dec.rf_w = 1'b1;
            end
            OP_ANDI: begin
                w_dec.aluc = ALUC_AND;
                w_dec.imm  = IMM_ZEXT;
                w_dec.wreg = w_rt;
                w_dec.rf_w = 1'b1;
            end
            OP_ORI: begin
                w_dec.aluc = ALUC_OR;
                w_dec.imm  = IMM_ZEXT;
                w_dec.wreg = w_rt;
                w_dec.rf_w = 1'b1;
            end
            OP_XORI: begin
                w_dec.aluc = ALUC_XOR;
                w_dec.imm  = IMM_ZEXT;
                w_dec.wreg = w_rt;
                w_dec.rf_w = 1'b1;
            end
            OP_LUI: begin
                w_dec.aluc  = ALUC_SLL;
                w_dec.imm   = IMM_ZEXT;
                w_dec.shamt = LUI_SHAMT;
                w_dec.wreg  = w_rt;
                w_dec.rf_w  = 1'b1;
            end
            OP_LW: begin
                w_dec.aluc  = ALUC_ADD;
                w_dec.imm   = IMM_SEXT;
                w_dec.wreg  = w_rt;
                w_dec.rf_w  = 1'b1;
                w_dec.mem_r = 1'b1;
            end
            OP_SW: begin
                w_dec.aluc   = ALUC_ADD;
                w_dec.imm    = IMM_SEXT;
                w_dec.rt_src = 1'b1;
                w_dec.mem_w  = 1'b1;
            end
            OP_BEQ: begin
                w_dec.aluc   = ALUC_SUB;
                w_dec.rt_src = 1'b1;
            end
            default: w_dec.illegal = 1'b1;
        endcase
        if (w_dec.illegal) begin
            w_dec.aluc   = ALUC_ADD;
            w_dec.imm    = IMM_NONE;
            w_dec.wreg   = 5'd0;
            w_dec.shamt  = 5'd0;
            w_dec.rt_src = 1'b0;
            w_dec.rf_w   = 1'b0;
            w_dec.mem_r  = 1'b0;
            w_dec.mem_w  = 1'b0;
        end
        if (w_dec.wreg == 5'd0)
            w_dec.rf_w = 1'b0;
    end

    assign o_dec = w_dec;

endmodule

// File: rtl/alu_issue.sv
// ID/EX issue slot for the ALU: decode, load-use bubble FSM,
// stall/flush handling and the registered EX operand bundle.
module alu_issue
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_rs_val,
    input  logic [31:0] id_rt_val,
    output logic        id_ready,
    input  logic        ex_stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [4:0]  ex_shamt,
    output logic [3:0]  ex_aluc,
    output logic        ex_rf_w,
    output logic [4:0]  ex_wreg,
    output logic        ex_mem_r,
    output logic        ex_mem_w,
    output logic        ex_illegal
);

    dec_t      w_dec;
    ex_t       w_ex_new;
    ex_t       r_ex;
    issue_st_t r_state;
    issue_st_t w_state_nxt;
    logic      w_hazard;
    logic      w_ready;
    logic      w_accept;

    alu_decode u_dec (
        .i_instr (id_instr),
        .o_dec   (w_dec)
    );

    // Load-use check against a load currently held in EX
    always_comb begin
        w_hazard = 1'b0;
        if (r_state == ST_RUN && id_valid && r_ex.valid &&
            r_ex.mem_r && r_ex.wreg != 5'd0)
            w_hazard = (r_ex.wreg == w_dec.rs) ||
                       (w_dec.rt_src && r_ex.wreg == w_dec.rt);
    end

    // Assemble the EX bundle for the instruction in decode
    always_comb begin
        w_ex_new         = '0;
        w_ex_new.valid   = 1'b1;
        w_ex_new.a       = id_rs_val;
        w_ex_new.b       = ext_imm(w_dec.imm, id_instr[15:0], id_rt_val);
        w_ex_new.shamt   = w_dec.shamt;
        w_ex_new.aluc    = w_dec.aluc;
        w_ex_new.rf_w    = w_dec.rf_w;
        w_ex_new.wreg    = w_dec.wreg;
        w_ex_new.mem_r   = w_dec.mem_r;
        w_ex_new.mem_w   = w_dec.mem_w;
        w_ex_new.illegal = w_dec.illegal;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_RUN;
        else
            r_state <= w_state_nxt;
    end

    // FSM next state: flush > stall > hazard; bubble lasts one cycle
    always_comb begin
        w_state_nxt = ST_RUN;
        if (flush)
            w_state_nxt = ST_RUN;
        else if (ex_stall)
            w_state_nxt = r_state;
        else if (w_hazard)
            w_state_nxt = ST_BUBBLE;
    end

    // FSM outputs: handshake back to decode
    always_comb begin
        w_ready  = !rst && !ex_stall && !w_hazard;
        w_accept = id_valid && w_ready;
    end

    // ID/EX register: reset > flush > stall hold > load or bubble
    always_ff @(posedge clk) begin
        if (rst)
            r_ex <= '0;
        else if (flush)
            r_ex <= '0;
        else if (ex_stall)
            r_ex <= r_ex;
        else if (w_accept)
            r_ex <= w_ex_new;
        else
            r_ex <= '0;
    end

    assign id_ready   = w_ready;
    assign ex_valid   = r_ex.valid;
    assign ex_a       = r_ex.a;
    assign ex_b       = r_ex.b;
    assign ex_shamt   = r_ex.shamt;
    assign ex_aluc    = r_ex.aluc;
    assign ex_rf_w    = r_ex.rf_w;
    assign ex_wreg    = r_ex.wreg;
    assign ex_mem_r   = r_ex.mem_r;
    assign ex_mem_w   = r_ex.mem_w;
    assign ex_illegal = r_ex.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios then random traffic
// checked against a cycle-level behavioural issue model.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_rs_val;
    logic [31:0] id_rt_val;
    logic        id_ready;
    logic        ex_stall;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [4:0]  ex_shamt;
    logic [3:0]  ex_aluc;
    logic        ex_rf_w;
    logic [4:0]  ex_wreg;
    logic        ex_mem_r;
    logic        ex_mem_w;
    logic        ex_illegal;

    int n_asserts = 0;
    int n_fails   = 0;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_rs_val  (id_rs_val),
        .id_rt_val  (id_rt_val),
        .id_ready   (id_ready),
        .ex_stall   (ex_stall),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .ex_shamt   (ex_shamt),
        .ex_aluc    (ex_aluc),
        .ex_rf_w    (ex_rf_w),
        .ex_wreg    (ex_wreg),
        .ex_mem_r   (ex_mem_r),
        .ex_mem_w   (ex_mem_w),
        .ex_illegal (ex_illegal)
    );

    typedef struct {
        bit        valid;
        bit [31:0] a;
        bit [31:0] b;
        bit [4:0]  shamt;
        bit [3:0]  aluc;
        bit        rf_w;
        bit [4:0]  wreg;
        bit        mem_r;
        bit        mem_w;
        bit        illegal;
        bit        has_dest;
        bit        rt_src;
        bit        zero;
    } mex_t;

    mex_t m_ex;
    bit   m_bub;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op,
        input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [5:0] fn,
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
        input logic [4:0] sa);
        return {6'h00, rs, rt, rd, sa, fn};
    endfunction

    // Expected EX contents for one instruction, straight from the ISA table
    function automatic mex_t mdec(input logic [31:0] ins,
        input logic [31:0] rsv, input logic [31:0] rtv);
        mex_t e;
        logic [31:0] sx;
        logic [31:0] zx;
        e = '{default: 0};
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'h0, ins[15:0]};
        e.valid = 1;
        e.a = rsv;
        case (ins[31:26])
            6'h00: begin
                e.b = rtv;
                e.wreg = ins[15:11];
                e.has_dest = 1;
                e.rt_src = 1;
                case (ins[5:0])
                    6'h20: e.aluc = 4'h2;
                    6'h21: e.aluc = 4'h0;
                    6'h22, 6'h23, 6'h2a: e.aluc = 4'h1;
                    6'h24: e.aluc = 4'h3;
                    6'h25: e.aluc = 4'h4;
                    6'h26: e.aluc = 4'h6;
                    6'h27: e.aluc = 4'h5;
                    6'h0a: e.aluc = 4'he;
                    6'h0b: e.aluc = 4'hc;
                    6'h00: begin
                        e.aluc = 4'h8;
                        e.shamt = ins[10:6];
                    end
                    default: e.illegal = 1;
                endcase
            end
            6'h08: begin e.aluc = 4'h2; e.b = sx; e.wreg = ins[20:16]; e.has_dest = 1; end
            6'h09: begin e.aluc = 4'h0; e.b = sx; e.wreg = ins[20:16]; e.has_dest = 1; end
            6'h0c: begin e.aluc = 4'h3; e.b = zx; e.wreg = ins[20:16]; e.has_dest = 1; end
            6'h0d: begin e.aluc = 4'h4; e.b = zx; e.wreg = ins[20:16]; e.has_dest = 1; end
            6'h0e: begin e.aluc = 4'h6; e.b = zx; e.wreg = ins[20:16]; e.has_dest = 1; end
            6'h0f: begin
                e.aluc = 4'h8; e.b = zx; e.shamt = 5'd16;
                e.wreg = ins[20:16]; e.has_dest = 1;
            end
            6'h23: begin
                e.aluc = 4'h0; e.b = sx; e.wreg = ins[20:16];
                e.has_dest = 1; e.mem_r = 1;
            end
            6'h2b: begin e.aluc = 4'h0; e.b = sx; e.mem_w = 1; e.rt_src = 1; end
            6'h04: begin e.aluc = 4'h1; e.b = rtv; e.rt_src = 1; end
            default: e.illegal = 1;
        endcase
        if (e.illegal) begin
            e.aluc = 0; e.has_dest = 0; e.rt_src = 0;
            e.mem_r = 0; e.mem_w = 0;
        end
        e.rf_w = e.has_dest && (e.wreg != 0);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] fns [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                 6'h26, 6'h27, 6'h2a, 6'h00, 6'h0a, 6'h0b};
        logic [5:0] ops [9] = '{6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e,
                                6'h0f, 6'h23, 6'h2b, 6'h04};
        int k = $urandom_range(0, 25);
        logic [4:0] rs = 5'($urandom_range(0, 3));
        logic [4:0] rt = 5'($urandom_range(0, 3));
        logic [4:0] rd = 5'($urandom_range(0, 3));
        logic [4:0] sa = 5'($urandom);
        logic [15:0] imm = 16'($urandom);
        if (k < 12) return rtype(fns[k], rs, rt, rd, sa);
        if (k < 21) return itype(ops[k-12], rs, rt, imm);
        if (k < 24) return itype(6'h23, rs, rt, imm);
        if (k == 24) return itype(6'h3f, rs, rt, imm);
        return itype(6'h02, rs, rt, imm);
    endfunction

    // One clock: check handshake before the edge, EX bundle after it
    task automatic step();
        mex_t nx;
        bit haz;
        nx = mdec(id_instr, id_rs_val, id_rt_val);
        haz = !m_bub && id_valid && m_ex.valid && m_ex.mem_r &&
              (m_ex.wreg != 0) &&
              ((m_ex.wreg == id_instr[25:21]) ||
               (nx.rt_src && m_ex.wreg == id_instr[20:16]));
        #1;
        if (!rst)
            chk("id_ready", 32'(id_ready), 32'(!ex_stall && !haz));
        @(posedge clk);
        #1;
        if (rst) begin
            m_ex = '{default: 0};
            m_ex.zero = 1;
            m_bub = 0;
        end else if (flush) begin
            m_ex = '{default: 0};
            m_bub = 0;
        end else if (ex_stall) begin
            m_ex = m_ex;
        end else if (haz) begin
            m_ex = '{default: 0};
            m_bub = 1;
        end else begin
            m_bub = 0;
            if (id_valid) m_ex = nx;
            else m_ex = '{default: 0};
        end
        chk("ex_valid", 32'(ex_valid), 32'(m_ex.valid));
        if (m_ex.zero) begin
            chk("rst_a", ex_a, 0);
            chk("rst_b", ex_b, 0);
            chk("rst_shamt", 32'(ex_shamt), 0);
            chk("rst_aluc", 32'(ex_aluc), 0);
            chk("rst_rf_w", 32'(ex_rf_w), 0);
            chk("rst_wreg", 32'(ex_wreg), 0);
            chk("rst_mem_r", 32'(ex_mem_r), 0);
            chk("rst_mem_w", 32'(ex_mem_w), 0);
            chk("rst_illegal", 32'(ex_illegal), 0);
        end else if (m_ex.valid) begin
            chk("ex_illegal", 32'(ex_illegal), 32'(m_ex.illegal));
            chk("ex_aluc", 32'(ex_aluc), 32'(m_ex.aluc));
            chk("ex_rf_w", 32'(ex_rf_w), 32'(m_ex.rf_w));
            chk("ex_mem_r", 32'(ex_mem_r), 32'(m_ex.mem_r));
            chk("ex_mem_w", 32'(ex_mem_w), 32'(m_ex.mem_w));
            if (!m_ex.illegal) begin
                chk("ex_a", ex_a, m_ex.a);
                chk("ex_b", ex_b, m_ex.b);
                chk("ex_shamt", 32'(ex_shamt), 32'(m_ex.shamt));
            end
            if (m_ex.has_dest)
                chk("ex_wreg", 32'(ex_wreg), 32'(m_ex.wreg));
        end
    endtask

    initial begin
        m_ex = '{default: 0};
        m_bub = 0;
        rst = 1; flush = 1; ex_stall = 1; id_valid = 1;
        id_instr = itype(6'h08, 5'd9, 5'd8, 16'hffff);
        id_rs_val = 32'd5; id_rt_val = 32'd7;

        // reset wins over flush and stall
        step();
        flush = 0; ex_stall = 0; id_valid = 0;
        step();
        rst = 0;

        // addi $t0,$t1,-1 with rs=5
        id_valid = 1;
        id_instr = itype(6'h08, 5'd9, 5'd8, 16'hffff);
        id_rs_val = 32'd5;
        step();
        chk("addi_aluc", 32'(ex_aluc), 32'h2);
        chk("addi_a", ex_a, 32'd5);
        chk("addi_b", ex_b, 32'hffffffff);
        chk("addi_wreg", 32'(ex_wreg), 32'd8);
        chk("addi_rf_w", 32'(ex_rf_w), 32'd1);

        // lui $t2,0x1234
        id_instr = itype(6'h0f, 5'd0, 5'd10, 16'h1234);
        id_rs_val = 32'h0;
        step();
        chk("lui_aluc", 32'(ex_aluc), 32'h8);
        chk("lui_b", ex_b, 32'h00001234);
        chk("lui_shamt", 32'(ex_shamt), 32'd16);
        chk("lui_result", ex_b << ex_shamt, 32'h12340000);

        // lw $t0,0($s0) then add $t1,$t0,$t0 -> one bubble
        id_instr = itype(6'h23, 5'd16, 5'd8, 16'h0);
        id_rs_val = 32'h1000;
        step();
        id_instr = rtype(6'h20, 5'd8, 5'd8, 5'd9, 5'd0);
        id_rs_val = 32'd3; id_rt_val = 32'd3;
        step();
        chk("bubble_valid", 32'(ex_valid), 32'd0);
        step();
        chk("after_bubble_valid", 32'(ex_valid), 32'd1);
        chk("after_bubble_wreg", 32'(ex_wreg), 32'd9);

        // stall three cycles with a new instruction waiting
        id_instr = itype(6'h0d, 5'd1, 5'd2, 16'hbeef);
        ex_stall = 1;
        repeat (3) step();
        chk("stall_aluc_held", 32'(ex_aluc), 32'h2);
        flush = 1;
        step();
        chk("flush_stall_valid", 32'(ex_valid), 32'd0);
        flush = 0; ex_stall = 0;

        // illegal opcode, then addu writing $0
        id_instr = itype(6'h3f, 5'd1, 5'd2, 16'h0);
        step();
        chk("illegal_flag", 32'(ex_illegal), 32'd1);
        chk("illegal_rf_w", 32'(ex_rf_w), 32'd0);
        id_instr = rtype(6'h21, 5'd1, 5'd2, 5'd0, 5'd0);
        step();
        chk("addu_r0_rf_w", 32'(ex_rf_w), 32'd0);

        // reset while in the bubble state
        id_instr = itype(6'h23, 5'd16, 5'd8, 16'h4);
        step();
        id_instr = rtype(6'h20, 5'd8, 5'd8, 5'd9, 5'd0);
        step();
        rst = 1; id_valid = 0;
        step();
        rst = 0; id_valid = 1;
        step();
        chk("post_rst_issue", 32'(ex_valid), 32'd1);
        chk("post_rst_wreg", 32'(ex_wreg), 32'd9);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            flush = ($urandom_range(0, 99) < 6);
            ex_stall = ($urandom_range(0, 99) < 15);
            id_valid = ($urandom_range(0, 99) < 85);
            id_instr = rand_instr();
            id_rs_val = $urandom;
            id_rt_val = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have ports: id_valid  in  1  decode slot holds an instruction; id_instr  in  32  MIPS instruction word; id_rs_val  in  32  rs register value; id_rt_val  in  32  rt register value; id_ready  out  1  instruction accepted this cycle.
REQ-003 SHALL have ports: ex_stall  in  1  EX stage frozen downstream; flush  in  1  kill instruction entering EX.
REQ-004 SHALL have ports: ex_valid  out  1; ex_a  out  32; ex_b  out  32; ex_shamt  out  5; ex_aluc  out  4; ex_rf_w  out  1; ex_wreg  out  5; ex_mem_r  out  1; ex_mem_w  out  1; ex_illegal  out  1. All are registered ID/EX outputs that feed the ALU and later stages.

Function
REQ-005 SHALL decode the aluc value as follows: 0000 add no-overflow; 0010 add with overflow; 0001 sub; 0011 and; 0100 or; 0110 xor; 0101 nor; 1000 b<<shamt; 1110 movz; 1100 movn.
REQ-006 SHALL map R-type instructions (op=000000) by funct: add 100000->0010; addu 100001->0000; sub 100010 and subu 100011->0001; and 100100->0011; or 100101->0100; xor 100110->0110; nor 100111->0101; slt 101010->0001; sll 000000->1000; movz 001010->1110; movn 001011->1100. For these, a=rs_val, b=rt_val, wreg=rd.
REQ-007 SHALL map I-type instructions as follows: addi 001000->0010 with sign-extended imm; addiu 001001->0000 with sign-extended imm; andi 001100->0011 with zero-extended imm; ori 001101->0100 with zero-extended imm; xori 001110->0110 with zero-extended imm. For these, a=rs_val, b=imm, wreg=rt.
REQ-008 SHALL decode lui 001111 as aluc=1000, b=zero-extended imm, shamt=16, wreg=rt.
REQ-009 SHALL decode lw 100011 as aluc=0000 with sign-extended imm and mem_r=1. SHALL decode sw 101011 as aluc=0000 with sign-extended imm, mem_w=1, rf_w=0. SHALL decode beq 000100 as aluc=0001, b=rt_val, rf_w=0.
REQ-010 SHALL set shamt=instr[10:6] for sll and 0 for every other non-lui instruction.
REQ-011 SHALL force ex_rf_w=0 whenever the destination register is $0.
REQ-012 SHALL treat any unlisted op/funct as illegal: ex_illegal=1, aluc=0000, rf_w=0, mem_r=0, mem_w=0, ex_valid=1.
REQ-013 SHALL implement a two-state FSM with states RUN and BUBBLE.
REQ-014 In RUN, a load-use hazard exists when ex_valid, ex_mem_r, ex_wreg!=0, and the incoming instruction has ex_wreg==rs, or ex_wreg==rt where rt is a source (R-type, sw, beq). On a hazard: id_ready=0, the EX register loads a bubble (ex_valid=0), and the FSM goes to BUBBLE.
REQ-015 In BUBBLE, the hazard check is suppressed and the FSM returns to RUN after one cycle.
REQ-016 id_ready SHALL be 1 when there is no ex_stall and no hazard. It SHALL be 1 whenever id_valid=0 and ex_stall=0.
REQ-017 Precedence each cycle SHALL be flush > ex_stall > hazard > normal load. flush clears ex_valid and returns the FSM to RUN. ex_stall holds every EX output and the FSM state unchanged, and drives id_ready=0.
REQ-018 If no instruction is accepted and no stall is active, the block SHALL load ex_valid=0. Latency from acceptance to EX output SHALL be one cycle.

Reset
REQ-019 On rst, all outputs SHALL be 0 at the next edge and the FSM SHALL enter RUN. rst SHALL take precedence over flush and ex_stall.
REQ-020 rst asserted mid-hazard SHALL drop any pending bubble with no replay.

Structure
REQ-021 The aluc codes and the opcode/funct constants SHALL live in a shared package, cpu_defs, which alu also uses.
REQ-022 Combinational decode SHALL be a single sub-module, alu_decode (instr -> aluc, imm mode, wreg, flags). The FSM and the ID/EX register SHALL stay in alu_issue.

Verification
REQ-023 addi $t0,$t1,-1 with rs_val=5 -> next cycle: aluc=0010, a=5, b=FFFFFFFF, wreg=8, rf_w=1.
REQ-024 lui $t2,0x1234 -> aluc=1000, b=00001234, shamt=16. The alu result must be 12340000.
REQ-025 lw $t0,0($s0) followed by add $t1,$t0,$t0 -> one bubble (ex_valid=0, id_ready=0), then the add is issued.
REQ-026 ex_stall held for 3 cycles -> all EX outputs frozen and id_ready=0 throughout. flush together with ex_stall -> ex_valid=0 next cycle.
REQ-027 Illegal op 111111 -> ex_illegal=1 and rf_w=0. addu with rd=$0 -> rf_w=0.
REQ-028 rst asserted in BUBBLE -> all outputs 0, FSM in RUN, and the next hazard-free instruction is accepted immediately.
